// File: rtl/alu_writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// alu_writeback_stage_pkg
//   Shared CPU datapath definitions used by the ALU result/flag writeback
//   stage and its skid buffer:
//     DATA_WIDTH        ALU result width
//     REG_ADDR_W        register-file index width
//     CNT_W             stall counter width (used with ALU_WB_STALL_CNT_EN)
//     WB_FIFO_DEPTH     number of buffered results
//     struct_alu_flag_t {carry, zero, sign} ALU condition flags
//     wb_entry_t        {data, addr} one pending register-file write
//   Helper: fifo_count_next() computes the occupancy after a push/pop.
// -----------------------------------------------------------------------------
package alu_writeback_stage_pkg;

    localparam int unsigned DATA_WIDTH    = 16;
    localparam int unsigned REG_ADDR_W    = 3;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned WB_FIFO_DEPTH = 2;

    // Carry sits in the MSB so that {carry, zero, sign} reads naturally as 3 bits.
    typedef struct packed {
        logic carry;
        logic zero;
        logic sign;
    } struct_alu_flag_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [REG_ADDR_W-1:0] addr;
    } wb_entry_t;

    // Occupancy after one edge. Callers guarantee push never happens when full
    // and pop never happens when empty, so the result stays within 0..2.
    function automatic logic [1:0] fifo_count_next(
        input logic [1:0] count,
        input logic       push,
        input logic       pop
    );
        logic [1:0] result;
        result = count;
        if (push && !pop) begin
            result = count + 2'd1;
        end else if (pop && !push) begin
            result = count - 2'd1;
        end
        return result;
    endfunction

endpackage : alu_writeback_stage_pkg

// File: rtl/alu_writeback_stage_wb_skid_fifo.sv
// -----------------------------------------------------------------------------
// wb_skid_fifo
//   Two-entry circular buffer between the ALU result stage and the register
//   file write port. One-bit read/write pointers plus an explicit count.
//   in_ready depends only on the local count, so there is no combinational
//   path from the write-port handshake back to the producer.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   flush             empty the buffer on the next edge (beats push/pop)
//   push, push_entry  write one entry (ignored when full)
//   pop               consume the head entry (ignored when empty)
//   in_ready          buffer has space (count != 2)
//   head_valid        buffer holds at least one entry
//   head_entry        oldest entry; stable until popped
// -----------------------------------------------------------------------------
module wb_skid_fifo
    import alu_writeback_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      in_ready,
    output logic      head_valid,
    output wb_entry_t head_entry
);

    wb_entry_t  slot_q [WB_FIFO_DEPTH];
    wb_entry_t  slot_d [WB_FIFO_DEPTH];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    logic       full;
    logic       empty;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count_q == 2'(WB_FIFO_DEPTH));
    assign empty   = (count_q == 2'd0);

    // Defensive qualification: an illegal push/pop is simply ignored.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointer and count update. Flush returns the buffer to its reset
    // arrangement so the next push lands in slot 0 again.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = fifo_count_next(count_q, push_ok, pop_ok);
        end
    end

    // Storage update. Slots are left untouched by flush; the count alone
    // decides whether their contents are live.
    always_comb begin
        for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
            slot_d[i] = slot_q[i];
            if (!flush && push_ok && (wr_ptr_q == 1'(i))) begin
                slot_d[i] = push_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign in_ready   = !full;
    assign head_valid = !empty;
    // Head is read straight from a flop, so it cannot change while the
    // consumer is stalling; only a pop moves rd_ptr_q.
    assign head_entry = slot_q[rd_ptr_q];

endmodule : wb_skid_fifo

// File: rtl/alu_writeback_stage.sv
// -----------------------------------------------------------------------------
// alu_writeback_stage
//   Result/flag stage directly after the ALU in the 16-bit CPU datapath.
//   Accepts ALU results under valid/ready, holds the architectural flag
//   register (carry fed back to the ALU), and buffers up to two results for
//   the register-file write port.
//   Optional build macro: ALU_WB_STALL_CNT_EN adds a saturating stall_cnt
//   output counting cycles where the write port holds off a valid result.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           ALU result handshake (in_ready = !full)
//   alu_out, alu_out_flag         result and {carry, zero, sign}
//   in_dest                       destination register index
//   in_flag_we / in_reg_we        update flags / write a register
//   flush                         drop all buffered, unwritten results
//   wb_valid / wb_ready           register-file write handshake
//   wb_data, wb_addr              head entry
//   flag_q, carry_q               architectural flags, carry for the ALU
//   stall_cnt                     (ALU_WB_STALL_CNT_EN only)
// -----------------------------------------------------------------------------
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  struct_alu_flag_t      alu_out_flag,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic                  in_flag_we,
    input  logic                  in_reg_we,
    input  logic                  flush,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output struct_alu_flag_t      flag_q,
`ifdef ALU_WB_STALL_CNT_EN
    output logic                  carry_q,
    output logic [CNT_W-1:0]      stall_cnt
`else
    output logic                  carry_q
`endif
);

    logic             accept;
    logic             drain;
    logic             push;
    wb_entry_t        push_entry;
    wb_entry_t        head_entry;
    struct_alu_flag_t flag_d;

    assign accept = in_valid && in_ready;
    assign drain  = wb_valid && wb_ready;

    // Flags-only instructions (CMP and friends) never occupy a buffer slot,
    // and a flush cancels whatever was accepted alongside it.
    assign push            = accept && in_reg_we && !flush;
    assign push_entry.data = alu_out;
    assign push_entry.addr = in_dest;

    wb_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .in_ready   (in_ready),
        .head_valid (wb_valid),
        .head_entry (head_entry)
    );

    assign wb_data = head_entry.data;
    assign wb_addr = head_entry.addr;

    // Flag register. Carry is only visible to the ALU from the cycle after
    // the accepting edge; there is deliberately no combinational bypass.
    always_comb begin
        flag_d = flag_q;
        if (accept && in_flag_we && !flush) begin
            flag_d = alu_out_flag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign carry_q = flag_q.carry;

`ifdef ALU_WB_STALL_CNT_EN
    // Counts cycles where a result is waiting on the register file.
    // Saturates instead of wrapping; only reset clears it, so it keeps
    // accumulating across flushes.
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wb_valid && !wb_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule : alu_writeback_stage

// File: tb/tb_alu_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_writeback_stage
//   Self-checking bench: a queue-based reference model tracks the pending
//   register writes and the flag register; a compare process checks every
//   cycle, and directed sequences pin literal values. Randomised traffic
//   follows the directed part.
// -----------------------------------------------------------------------------
module tb_alu_writeback_stage;
    import alu_writeback_stage_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] alu_out;
    logic [2:0]            alu_out_flag;
    logic [REG_ADDR_W-1:0] in_dest;
    logic                  in_flag_we;
    logic                  in_reg_we;
    logic                  flush;
    logic                  wb_valid;
    logic                  wb_ready;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [2:0]            flag_q;
    logic                  carry_q;
`ifdef ALU_WB_STALL_CNT_EN
    logic [CNT_W-1:0]      stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_writeback_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_out      (alu_out),
        .alu_out_flag (alu_out_flag),
        .in_dest      (in_dest),
        .in_flag_we   (in_flag_we),
        .in_reg_we    (in_reg_we),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_data      (wb_data),
        .wb_addr      (wb_addr),
        .flag_q       (flag_q),
`ifdef ALU_WB_STALL_CNT_EN
        .carry_q      (carry_q),
        .stall_cnt    (stall_cnt)
`else
        .carry_q      (carry_q)
`endif
    );

    // ---------------- reference model ----------------
    logic [DATA_WIDTH-1:0] m_data[$];
    logic [REG_ADDR_W-1:0] m_addr[$];
    logic [2:0]            m_flags = 3'b000;
    int unsigned           m_stall = 0;

    always @(posedge clk) begin
        bit has_head;
        bit acc;
        has_head = (m_data.size() != 0);
        if (!rst && has_head && !wb_ready && m_stall < 32'hFFFF) m_stall++;
        if (rst) begin
            m_data.delete();
            m_addr.delete();
            m_flags = 3'b000;
            m_stall = 0;
        end else if (flush) begin
            m_data.delete();
            m_addr.delete();
        end else begin
            acc = in_valid && (m_data.size() < 2);
            if (has_head && wb_ready) begin
                void'(m_data.pop_front());
                void'(m_addr.pop_front());
            end
            if (acc && in_reg_we) begin
                m_data.push_back(alu_out);
                m_addr.push_back(in_dest);
            end
            if (acc && in_flag_we) m_flags = alu_out_flag;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_wb_valid", 32'(wb_valid), 32'(m_data.size() != 0));
            check("model_in_ready", 32'(in_ready), 32'(m_data.size() < 2));
            check("model_flag_q", 32'(flag_q), 32'(m_flags));
            check("model_carry_q", 32'(carry_q), 32'(m_flags[2]));
            if (m_data.size() != 0) begin
                check("model_wb_data", 32'(wb_data), 32'(m_data[0]));
                check("model_wb_addr", 32'(wb_addr), 32'(m_addr[0]));
            end
`ifdef ALU_WB_STALL_CNT_EN
            check("model_stall_cnt", 32'(stall_cnt), m_stall);
`endif
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [2:0] dest,
                         input logic [2:0] fl, input logic rwe, input logic fwe);
        in_valid     = v;
        alu_out      = d;
        in_dest      = dest;
        alu_out_flag = fl;
        in_reg_we    = rwe;
        in_flag_we   = fwe;
    endtask

    initial begin
        int rcv;
        logic [15:0] exp_next;
        bit beef_seen;

        rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);

        // 1: reset
        tick(); tick();
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_flag_q", 32'(flag_q), 32'd0);
        check("rst_carry_q", 32'(carry_q), 32'd0);
        check("rst_wb_data", 32'(wb_data), 32'd0);
        check("rst_wb_addr", 32'(wb_addr), 32'd0);
        rst = 1'b0;
        cmp_en = 1'b1;
        $display("txn reset done");

        // 2: single op
        drive(1'b1, 16'h1234, 3'd3, 3'b100, 1'b1, 1'b1);
        tick();
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
        check("single_wb_valid", 32'(wb_valid), 32'd1);
        check("single_wb_data", 32'(wb_data), 32'h1234);
        check("single_wb_addr", 32'(wb_addr), 32'd3);
        check("single_carry_q", 32'(carry_q), 32'd1);
        tick();
        check("single_drained", 32'(wb_valid), 32'd0);
        $display("txn single op data=1234 dest=3");

        // 3: back-pressure
        wb_ready = 1'b0;
        drive(1'b1, 16'h0001, 3'd1, 3'b000, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0002, 3'd2, 3'b000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        repeat (5) tick();
        check("bp_hold_data", 32'(wb_data), 32'h0001);
        check("bp_hold_valid", 32'(wb_valid), 32'd1);
        wb_ready = 1'b1;
        tick();
        check("bp_second_data", 32'(wb_data), 32'h0002);
        check("bp_in_ready_free", 32'(in_ready), 32'd1);
        tick();
        check("bp_empty", 32'(wb_valid), 32'd0);
        $display("txn back-pressure drained 0001,0002");

        // 4: flags-only
        drive(1'b1, 16'h5555, 3'd5, 3'b010, 1'b0, 1'b1);
        tick();
        check("fonly_no_wb", 32'(wb_valid), 32'd0);
        check("fonly_flag_q", 32'(flag_q), 32'b010);
        check("fonly_carry_q", 32'(carry_q), 32'd0);
        drive(1'b1, 16'h6666, 3'd6, 3'b111, 1'b0, 1'b0);
        tick();
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
        check("fonly_flag_kept", 32'(flag_q), 32'b010);
        $display("txn flags-only flag_q=010");

        // 5: flush with a full buffer, then with one entry and a live accept
        beef_seen = 1'b0;
        wb_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 3'd1, 3'b000, 1'b1, 1'b0); tick();
        drive(1'b1, 16'hBBBB, 3'd2, 3'b000, 1'b1, 1'b0); tick();
        drive(1'b1, 16'hBEEF, 3'd7, 3'b111, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
        check("flush_full_wb_valid", 32'(wb_valid), 32'd0);
        check("flush_full_in_ready", 32'(in_ready), 32'd1);
        check("flush_full_flag_q", 32'(flag_q), 32'b010);
        drive(1'b1, 16'hCCCC, 3'd4, 3'b000, 1'b1, 1'b0); tick();
        drive(1'b1, 16'hBEEF, 3'd7, 3'b111, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
        check("flush_acc_wb_valid", 32'(wb_valid), 32'd0);
        check("flush_acc_flag_q", 32'(flag_q), 32'b010);
        wb_ready = 1'b1;
        repeat (3) begin
            tick();
            if (wb_valid && wb_data == 16'hBEEF) beef_seen = 1'b1;
        end
        check("flush_no_beef", 32'(beef_seen), 32'd0);
        $display("txn flush dropped buffered entries and BEEF");

        // 6: streaming, then reset mid-stream
        rcv = 0;
        exp_next = 16'h0100;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 16'h0100 + 16'(i), 3'(i), 3'(i | 1), 1'b1, 1'b1);
            tick();
            if (wb_valid) begin
                check("stream_order", 32'(wb_data), 32'(exp_next));
                exp_next++;
                rcv++;
            end
        end
        check("stream_count", 32'(rcv), 32'd100);
        $display("txn streaming received=%0d", rcv);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_wb_valid", 32'(wb_valid), 32'd0);
        check("midrst_flag_q", 32'(flag_q), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
        tick();
        $display("txn reset mid-stream");

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 3'($urandom), 3'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            wb_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 3'b000, 1'b0, 1'b0);
        wb_ready = 1'b1;
        repeat (3) tick();
        check("random_final_empty", 32'(wb_valid), 32'd0);
        $display("txn random traffic 600 cycles");

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_writeback_stage
